// File: rtl/conv_main_controller.sv
// Convolution job sequencer: kicks the IF/filter readers and address generator,
// clears pipeline registers between partial sums and counts output writes.
module conv_main_controller #(
    parameter int FILT_ADDR_LEN = 4,
    parameter int IF_ADDR_LEN   = 5,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [FILT_ADDR_LEN-1:0] filt_len_in,
    input  logic [IF_ADDR_LEN-1:0]   stride_len_in,
    input  logic                     psum_done,
    input  logic                     full_done,
    input  logic                     stride_count_flag,
    input  logic                     outbuf_write,
    output logic                     IF_read_start,
    output logic                     filter_read_start,
    output logic                     start_rd_gen,
    output logic                     regs_clr,
    output logic [FILT_ADDR_LEN-1:0] filt_len,
    output logic [IF_ADDR_LEN-1:0]   stride_len,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err,
    output logic [CNT_W-1:0]         psum_count,
    output logic [CNT_W-1:0]         stride_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GEN,
        RUN,
        CLR,
        FIN
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state;
    logic   cfg_ok;

    assign cfg_ok = (filt_len_in != '0) && (stride_len_in != '0);

    // Outputs are computed for the state being entered, so every output is a flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= IDLE;
            IF_read_start     <= 1'b0;
            filter_read_start <= 1'b0;
            start_rd_gen      <= 1'b0;
            regs_clr          <= 1'b0;
            filt_len          <= '0;
            stride_len        <= '0;
            ready             <= 1'b1;
            busy              <= 1'b0;
            done              <= 1'b0;
            cfg_err           <= 1'b0;
            psum_count        <= '0;
            stride_count      <= '0;
        end else begin
            IF_read_start     <= 1'b0;
            filter_read_start <= 1'b0;
            start_rd_gen      <= 1'b0;
            regs_clr          <= 1'b0;
            done              <= 1'b0;
            cfg_err           <= 1'b0;

            if (state != IDLE) begin
                if (outbuf_write && psum_count != CNT_MAX)
                    psum_count <= psum_count + CNT_ONE;
                if (stride_count_flag && stride_count != CNT_MAX)
                    stride_count <= stride_count + CNT_ONE;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            state             <= LOAD;
                            filt_len          <= filt_len_in;
                            stride_len        <= stride_len_in;
                            psum_count        <= '0;
                            stride_count      <= '0;
                            IF_read_start     <= 1'b1;
                            filter_read_start <= 1'b1;
                            regs_clr          <= 1'b1;
                            busy              <= 1'b1;
                            ready             <= 1'b0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state        <= GEN;
                    start_rd_gen <= 1'b1;
                end
                GEN: begin
                    state <= RUN;
                end
                RUN: begin
                    // Whole-IF completion wins over a coincident partial sum.
                    if (full_done) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else if (psum_done) begin
                        state    <= CLR;
                        regs_clr <= 1'b1;
                    end
                end
                CLR: begin
                    state <= RUN;
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_main_controller.sv
// Scoreboard bench for conv_main_controller: stimulus queues expected snapshots,
// a monitor compares them whenever a pulse output fires or a probe is raised.
module tb_conv_main_controller;

    typedef struct packed {
        logic [5:0]  p;
        logic        b;
        logic        r;
        logic [3:0]  fl;
        logic [4:0]  sl;
        logic [15:0] pc;
        logic [15:0] sc;
        logic [1:0]  pc2;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  filt_len_in = '0;
    logic [4:0]  stride_len_in = '0;
    logic        psum_done = 1'b0;
    logic        full_done = 1'b0;
    logic        stride_count_flag = 1'b0;
    logic        outbuf_write = 1'b0;
    logic        probe = 1'b0;

    logic        if_rs, flt_rs, rdg, rclr, rdy, bsy, dn, cerr;
    logic [3:0]  fl;
    logic [4:0]  sl;
    logic [15:0] pc, sc;

    logic        if_rs2, flt_rs2, rdg2, rclr2, rdy2, bsy2, dn2, cerr2;
    logic [3:0]  fl2;
    logic [4:0]  sl2;
    logic [1:0]  pc2, sc2;

    rec_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    conv_main_controller dut (
        .clk(clk), .rst(rst), .start(start),
        .filt_len_in(filt_len_in), .stride_len_in(stride_len_in),
        .psum_done(psum_done), .full_done(full_done),
        .stride_count_flag(stride_count_flag), .outbuf_write(outbuf_write),
        .IF_read_start(if_rs), .filter_read_start(flt_rs),
        .start_rd_gen(rdg), .regs_clr(rclr),
        .filt_len(fl), .stride_len(sl), .ready(rdy), .busy(bsy),
        .done(dn), .cfg_err(cerr), .psum_count(pc), .stride_count(sc)
    );

    conv_main_controller #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start),
        .filt_len_in(filt_len_in), .stride_len_in(stride_len_in),
        .psum_done(psum_done), .full_done(full_done),
        .stride_count_flag(stride_count_flag), .outbuf_write(outbuf_write),
        .IF_read_start(if_rs2), .filter_read_start(flt_rs2),
        .start_rd_gen(rdg2), .regs_clr(rclr2),
        .filt_len(fl2), .stride_len(sl2), .ready(rdy2), .busy(bsy2),
        .done(dn2), .cfg_err(cerr2), .psum_count(pc2), .stride_count(sc2)
    );

    localparam logic [5:0] P_NONE = 6'b000000;
    localparam logic [5:0] P_LOAD = 6'b110100;
    localparam logic [5:0] P_GEN  = 6'b001000;
    localparam logic [5:0] P_CLR  = 6'b000100;
    localparam logic [5:0] P_DONE = 6'b000010;
    localparam logic [5:0] P_CERR = 6'b000001;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [5:0] p, input logic b,
                             input logic [3:0] f, input logic [4:0] s,
                             input logic [15:0] c, input logic [15:0] t,
                             input logic [1:0] c2);
        rec_t e;
        e.p = p; e.b = b; e.r = ~b; e.fl = f; e.sl = s;
        e.pc = c; e.sc = t; e.pc2 = c2;
        exp_q.push_back(e);
    endtask

    // Probe forces a comparison in the current cycle, then advances one clock.
    task automatic probe_now();
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    always @(negedge clk) begin
        rec_t o, e;
        o = {if_rs, flt_rs, rdg, rclr, dn, cerr, bsy, rdy, fl, sl, pc, sc, pc2};
        if (o.p != 6'b0 || probe) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event t=%0t: got p=%b b=%b r=%b fl=%0d sl=%0d pc=%0d sc=%0d pc2=%0d, none required",
                         $time, o.p, o.b, o.r, o.fl, o.sl, o.pc, o.sc, o.pc2);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL event t=%0t: got p=%b b=%b r=%b fl=%0d sl=%0d pc=%0d sc=%0d pc2=%0d, required p=%b b=%b r=%b fl=%0d sl=%0d pc=%0d sc=%0d pc2=%0d",
                             $time, o.p, o.b, o.r, o.fl, o.sl, o.pc, o.sc, o.pc2,
                             e.p, e.b, e.r, e.fl, e.sl, e.pc, e.sc, e.pc2);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) tick();
        expect_ev(P_NONE, 0, 0, 0, 0, 0, 0);
        probe_now();
        rst = 1'b1;
        tick();

        // Job 1: filt 3 / stride 1, four partial sums then full_done
        start = 1'b1; filt_len_in = 4'd3; stride_len_in = 5'd1;
        tick();
        start = 1'b0;
        expect_ev(P_LOAD, 1, 3, 1, 0, 0, 0);
        tick();
        expect_ev(P_GEN, 1, 3, 1, 0, 0, 0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            psum_done = 1'b1; outbuf_write = 1'b1; stride_count_flag = 1'b1;
            tick();
            psum_done = 1'b0; outbuf_write = 1'b0; stride_count_flag = 1'b0;
            expect_ev(P_CLR, 1, 3, 1, 16'(i), 16'(i), (i > 3) ? 2'd3 : 2'(i));
            tick();
        end
        full_done = 1'b1;
        tick();
        full_done = 1'b0;
        expect_ev(P_DONE, 1, 3, 1, 4, 4, 3);
        tick();
        expect_ev(P_NONE, 0, 3, 1, 4, 4, 3);
        probe_now();

        // Bad config: filter length zero
        start = 1'b1; filt_len_in = 4'd0; stride_len_in = 5'd7;
        tick();
        start = 1'b0;
        expect_ev(P_CERR, 0, 3, 1, 4, 4, 3);
        tick();
        expect_ev(P_NONE, 0, 3, 1, 4, 4, 3);
        probe_now();

        // Job 2: start ignored while busy, 5 writes, psum+full together
        start = 1'b1; filt_len_in = 4'd5; stride_len_in = 5'd2;
        tick();
        expect_ev(P_LOAD, 1, 5, 2, 0, 0, 0);
        filt_len_in = 4'd9; stride_len_in = 5'd9;
        tick();
        expect_ev(P_GEN, 1, 5, 2, 0, 0, 0);
        tick();
        outbuf_write = 1'b1;
        repeat (5) tick();
        start = 1'b0; outbuf_write = 1'b0;
        expect_ev(P_NONE, 1, 5, 2, 5, 0, 3);
        probe_now();
        psum_done = 1'b1; full_done = 1'b1;
        tick();
        psum_done = 1'b0; full_done = 1'b0;
        expect_ev(P_DONE, 1, 5, 2, 5, 0, 3);
        tick();
        expect_ev(P_NONE, 0, 5, 2, 5, 0, 3);
        probe_now();

        // Job 3: reset mid-RUN aborts without done
        start = 1'b1; filt_len_in = 4'd3; stride_len_in = 5'd4;
        tick();
        start = 1'b0;
        expect_ev(P_LOAD, 1, 3, 4, 0, 0, 0);
        tick();
        expect_ev(P_GEN, 1, 3, 4, 0, 0, 0);
        tick();
        outbuf_write = 1'b1;
        tick();
        outbuf_write = 1'b0;
        full_done = 1'b1;
        rst = 1'b0;
        tick();
        full_done = 1'b0;
        expect_ev(P_NONE, 0, 0, 0, 0, 0, 0);
        probe_now();
        rst = 1'b1;
        repeat (2) tick();

        // Job 4: first start after reset accepted normally
        start = 1'b1; filt_len_in = 4'd2; stride_len_in = 5'd3;
        tick();
        start = 1'b0;
        expect_ev(P_LOAD, 1, 2, 3, 0, 0, 0);
        tick();
        expect_ev(P_GEN, 1, 2, 3, 0, 0, 0);
        tick();
        full_done = 1'b1;
        tick();
        full_done = 1'b0;
        expect_ev(P_DONE, 1, 2, 3, 0, 0, 0);
        tick();
        expect_ev(P_NONE, 0, 2, 3, 0, 0, 0);
        probe_now();
        repeat (3) tick();

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_events: got %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_main_controller.md
CONV_MAIN_CONTROLLER -- requirements
Module: conv_main_controller

Interface
REQ-001 Parameters SHALL be:
- FILT_ADDR_LEN, default 4, filter length/address width.
- IF_ADDR_LEN, default 5, stride length/IF address width.
- CNT_W, default 16, width of the status counters.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  job request, sampled in IDLE.
- filt_len_in  in  FILT_ADDR_LEN  job filter length.
- stride_len_in  in  IF_ADDR_LEN  job stride length.
- psum_done  in  1  datapath partial sum complete.
- full_done  in  1  datapath whole IF consumed.
- stride_count_flag  in  1  datapath stride-advance pulse.
- outbuf_write  in  1  datapath output-buffer write pulse.
- IF_read_start  out  1  IF reader kick.
- filter_read_start  out  1  filter reader kick.
- start_rd_gen  out  1  read-address generator kick.
- regs_clr  out  1  clears IF/mult/add pipeline registers.
- filt_len  out  FILT_ADDR_LEN  latched filter length.
- stride_len  out  IF_ADDR_LEN  latched stride length.
- ready  out  1  controller idle, accepts start.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
- cfg_err  out  1  one-cycle bad-config pulse.
- psum_count  out  CNT_W  outbuf writes in current/last job.
- stride_count  out  CNT_W  strides in current/last job.

REQ-003 All outputs SHALL be registered, with no combinational input-to-output path.

Function
REQ-004 The FSM states SHALL be IDLE, LOAD, GEN, RUN, CLR and FIN, one-hot or binary, updated on the rising edge of clk.

REQ-005 IDLE: ready=1, busy=0; start=1 with both lengths nonzero SHALL latch filt_len_in/stride_len_in into filt_len/stride_len, clear both counters, and go to LOAD.

REQ-006 IDLE: start=1 with filt_len_in==0 or stride_len_in==0 SHALL pulse cfg_err for exactly one cycle, stay in IDLE, and leave the latched lengths and counters unchanged.

REQ-007 LOAD (one cycle): IF_read_start=1, filter_read_start=1 and regs_clr=1 simultaneously, then go to GEN.

REQ-008 GEN (one cycle): start_rd_gen=1, then go to RUN.

REQ-009 RUN:
- full_done=1 -> FIN, taking priority over psum_done.
- else psum_done=1 -> CLR.
- else remain in RUN.

REQ-010 CLR (one cycle): regs_clr=1, then go to RUN; start_rd_gen is not re-asserted.

REQ-011 FIN (one cycle): done=1, then go to IDLE; ready SHALL rise in the cycle after done.

REQ-012 busy SHALL be 1 in every state except IDLE; ready SHALL equal ~busy.

REQ-013 IF_read_start, filter_read_start, start_rd_gen, regs_clr, done and cfg_err SHALL be one-cycle pulses, low in every state not listed above.

REQ-014 psum_count SHALL increment by 1 on each cycle with outbuf_write=1 while busy, saturate at 2^CNT_W-1, and hold its value in IDLE until the next accepted start.

REQ-015 stride_count SHALL follow the same rules as psum_count, driven by stride_count_flag.

REQ-016 start asserted while busy SHALL be ignored, with no state, length or counter change.

REQ-017 Datapath inputs outside RUN/CLR SHALL be ignored for FSM transitions, except for the counter updates of REQ-014 and REQ-015.

REQ-018 filt_len and stride_len SHALL stay constant from LOAD through FIN.

REQ-019 Minimum job latency: start accepted at cycle T -> IF_read_start at T+1, start_rd_gen at T+2, FIN no earlier than T+4.

Reset
REQ-020 rst=0 at a clock edge SHALL force IDLE and set every output to 0 except ready=1; this includes filt_len, stride_len and both counters.

REQ-021 Reset asserted mid-job (any state) SHALL abort the job with no done pulse; the first start after rst returns to 1 SHALL be accepted normally.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then start with filt_len_in=3, stride_len_in=1 -> IF_read_start/filter_read_start/regs_clr high at T+1, start_rd_gen at T+2, busy=1, filt_len=3.
- In RUN, psum_done pulsed 4 times with 4 outbuf_write pulses, then full_done -> regs_clr pulses 4 times (one cycle after each psum_done), done once, psum_count=4, ready=1 afterwards.
- psum_done and full_done asserted in the same RUN cycle -> FIN taken, no CLR regs_clr pulse, done=1 next cycle.
- start with filt_len_in=0 -> cfg_err=1 for one cycle, busy stays 0, filt_len unchanged.
- start re-asserted during RUN -> no kick pulses, lengths unchanged; rst=0 pulsed mid-RUN -> all outputs zero and ready=1 next cycle, no done pulse.
- CNT_W=2 with 5 outbuf_write pulses -> psum_count saturates at 3.
